// File: rtl/spi_reg_ctrl_if.sv
// rtl/spi_reg_ctrl_if.sv - SPI bridge / register-file handshake bundle for spi_reg_ctrl
interface spi_reg_ctrl_if #(
    parameter int ADDR_W = 6
);
    logic              cs_active;
    logic              rx_valid;
    logic [7:0]        rx_byte;
    logic [7:0]        tx_byte;
    logic              tx_load;
    logic [ADDR_W-1:0] reg_addr;
    logic [7:0]        reg_wdata;
    logic              reg_we;
    logic              reg_re;
    logic [7:0]        reg_rdata;
    logic              err_addr;

    // Bridge + register file side
    modport master (
        output cs_active, rx_valid, rx_byte, reg_rdata,
        input  tx_byte, tx_load, reg_addr, reg_wdata, reg_we, reg_re, err_addr
    );

    // Command sequencer side
    modport slave (
        input  cs_active, rx_valid, rx_byte, reg_rdata,
        output tx_byte, tx_load, reg_addr, reg_wdata, reg_we, reg_re, err_addr
    );
endinterface

// File: rtl/spi_reg_ctrl.sv
// rtl/spi_reg_ctrl.sv - SPI frame command sequencer issuing register read/write strobes
// Optional burst (auto-increment) mode: define SPI_AUTO_INC_EN.
module spi_reg_ctrl #(
    parameter int ADDR_W   = 6,
    parameter int NUM_REGS = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    spi_reg_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CMD    = 3'd1,
        WR     = 3'd2,
        RD_REQ = 3'd3,
        RD_CAP = 3'd4,
        RD     = 3'd5,
        DONE   = 3'd6
    } state_e;

    localparam logic [ADDR_W:0] NUM_REGS_L = (ADDR_W+1)'(NUM_REGS);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        tx_q, tx_d;
    logic              wr_pend_q, wr_pend_d;
    logic              addr_legal;
    logic [7:0]        rd_byte;

    assign addr_legal = ({1'b0, addr_q} < NUM_REGS_L);
    assign rd_byte    = addr_legal ? bus.reg_rdata : 8'h00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= 8'h00;
            tx_q      <= 8'h00;
            wr_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            tx_q      <= tx_d;
            wr_pend_q <= wr_pend_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        tx_d      = tx_q;
        wr_pend_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.cs_active) state_d = CMD;
            end
            CMD: begin
                if (bus.rx_valid) begin
                    addr_d  = bus.rx_byte[ADDR_W-1:0];
                    state_d = bus.rx_byte[7] ? WR : RD_REQ;
                end
            end
            WR: begin
`ifdef SPI_AUTO_INC_EN
                // Advance after the strobe cycle so reg_addr matches the write just issued
                if (wr_pend_q) addr_d = addr_q + 1'b1;
`endif
                if (bus.rx_valid) begin
                    wdata_d   = bus.rx_byte;
                    wr_pend_d = 1'b1;
`ifndef SPI_AUTO_INC_EN
                    state_d   = DONE;
`endif
                end
            end
            RD_REQ: state_d = RD_CAP;
            RD_CAP: begin
                tx_d    = rd_byte;
                state_d = RD;
            end
            RD: begin
                if (bus.rx_valid) begin
`ifdef SPI_AUTO_INC_EN
                    addr_d  = addr_q + 1'b1;
                    state_d = RD_REQ;
`else
                    state_d = DONE;
`endif
                end
            end
            DONE: state_d = DONE;
            default: state_d = IDLE;
        endcase

        // Chip-select release wins over everything, including a coincident byte
        if (!bus.cs_active) begin
            state_d   = IDLE;
            addr_d    = addr_q;
            wdata_d   = wdata_q;
            wr_pend_d = 1'b0;
            tx_d      = 8'h00;
        end
    end

    assign bus.reg_addr  = addr_q;
    assign bus.reg_wdata = wdata_q;
    assign bus.reg_re    = (state_q == RD_REQ) && addr_legal;
    assign bus.reg_we    = wr_pend_q && addr_legal;
    assign bus.err_addr  = ((state_q == RD_REQ) || wr_pend_q) && !addr_legal;
    assign bus.tx_load   = (state_q == RD_CAP);
    assign bus.tx_byte   = (state_q == RD_CAP) ? rd_byte : tx_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb/tb_spi_reg_ctrl.sv - randomized self-checking bench for spi_reg_ctrl
module tb_spi_reg_ctrl;

    localparam int AW = 6;
`ifdef SPI_AUTO_INC_EN
    localparam int NR = 64;
`else
    localparam int NR = 16;
`endif

    logic clk;
    logic rst_n;

    spi_reg_ctrl_if #(.ADDR_W(AW)) bus ();

    spi_reg_ctrl #(.ADDR_W(AW), .NUM_REGS(NR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference register contents and the register file the DUT actually talks to
    logic [7:0] model_mem [64];
    logic [7:0] tb_mem    [64];

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) tb_mem[i] <= model_mem[i];
            bus.reg_rdata <= 8'h00;
        end else begin
            if (bus.reg_we) tb_mem[bus.reg_addr] <= bus.reg_wdata;
            if (bus.reg_re) bus.reg_rdata <= tb_mem[bus.reg_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observation of DUT strobes, cleared at the start of each frame
    logic        clr_req;
    logic [13:0] obs_w[$];
    logic [7:0]  obs_tx[$];
    int          obs_re, obs_err, obs_bad, re_first, load_first;
    logic        prev_we, prev_re;

    always @(negedge clk) begin
        if (clr_req) begin
            obs_w.delete();
            obs_tx.delete();
            obs_re = 0; obs_err = 0; obs_bad = 0;
            re_first = -1; load_first = -1;
            prev_we = 1'b0; prev_re = 1'b0;
        end else begin
            if (bus.reg_we) obs_w.push_back({bus.reg_addr, bus.reg_wdata});
            if (bus.reg_re) begin
                if (re_first < 0) re_first = cyc;
                obs_re++;
            end
            if (bus.tx_load) begin
                if (load_first < 0) load_first = cyc;
                obs_tx.push_back(bus.tx_byte);
            end
            if (bus.err_addr) obs_err++;
            if ((bus.reg_we && bus.reg_re) || (bus.reg_we && prev_we) || (bus.reg_re && prev_re))
                obs_bad++;
            prev_we = bus.reg_we;
            prev_re = bus.reg_re;
        end
    end

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input string name, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3,
                             input int n, input bit drop_last);
        logic [7:0]  bs[4];
        logic [13:0] exp_w[$];
        logic [7:0]  exp_tx[$];
        logic [5:0]  a, ai;
        int          eff, exp_re, exp_err, nrd, cmd_cyc;
        bit          is_rd, first_legal;
        bs = '{b0, b1, b2, b3};
        eff = drop_last ? n - 1 : n;
        exp_re = 0; exp_err = 0; is_rd = 1'b0; first_legal = 1'b0; cmd_cyc = 0;

        if (eff >= 1) begin
            a = bs[0][5:0];
            if (bs[0][7]) begin
`ifdef SPI_AUTO_INC_EN
                for (int i = 1; i < eff; i++) begin
                    ai = a + 6'(i - 1);
                    if (int'(ai) < NR) begin
                        exp_w.push_back({ai, bs[i]});
                        model_mem[ai] = bs[i];
                    end else exp_err++;
                end
`else
                if (eff >= 2) begin
                    if (int'(a) < NR) begin
                        exp_w.push_back({a, bs[1]});
                        model_mem[a] = bs[1];
                    end else exp_err++;
                end
`endif
            end else begin
                is_rd = 1'b1;
                first_legal = (int'(a) < NR);
`ifdef SPI_AUTO_INC_EN
                nrd = eff;
`else
                nrd = 1;
`endif
                for (int i = 0; i < nrd; i++) begin
                    ai = a + 6'(i);
                    if (int'(ai) < NR) begin
                        exp_tx.push_back(model_mem[ai]);
                        exp_re++;
                    end else begin
                        exp_tx.push_back(8'h00);
                        exp_err++;
                    end
                end
            end
        end

        clr_req = 1'b1;
        tick(1);
        clr_req = 1'b0;
        bus.cs_active = 1'b1;
        tick(2);
        for (int i = 0; i < n; i++) begin
            bus.rx_valid = 1'b1;
            bus.rx_byte  = bs[i];
            if (drop_last && i == n - 1) bus.cs_active = 1'b0;
            if (i == 0) cmd_cyc = cyc;
            tick(1);
            bus.rx_valid = 1'b0;
            tick(9);
        end
        bus.cs_active = 1'b0;
        tick(3);

        check({name, ".tx_idle"}, bus.tx_byte, 8'h00);
        check({name, ".wr_n"}, obs_w.size(), exp_w.size());
        for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++)
            check({name, ".wr"}, obs_w[i], exp_w[i]);
        check({name, ".tx_n"}, obs_tx.size(), exp_tx.size());
        for (int i = 0; i < exp_tx.size() && i < obs_tx.size(); i++)
            check({name, ".tx"}, obs_tx[i], exp_tx[i]);
        check({name, ".re_n"}, obs_re, exp_re);
        check({name, ".err_n"}, obs_err, exp_err);
        check({name, ".strobe"}, obs_bad, 0);
        if (is_rd) begin
            check({name, ".load_lat"}, load_first - cmd_cyc, 2);
            if (first_legal) check({name, ".re_lat"}, re_first - cmd_cyc, 1);
        end
    endtask

    initial begin
        logic [7:0] r0;
        rst_n = 1'b0;
        clr_req = 1'b0;
        bus.cs_active = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_byte = 8'h00;
        for (int i = 0; i < 64; i++) model_mem[i] = 8'($urandom);
        tick(3);
        check("rst.tx_byte", bus.tx_byte, 8'h00);
        check("rst.tx_load", bus.tx_load, 1'b0);
        check("rst.reg_we", bus.reg_we, 1'b0);
        check("rst.reg_re", bus.reg_re, 1'b0);
        check("rst.err", bus.err_addr, 1'b0);
        check("rst.addr", bus.reg_addr, 6'd0);
        check("rst.wdata", bus.reg_wdata, 8'h00);
        rst_n = 1'b1;
        tick(2);

        run_frame("wr3", 8'h83, 8'h5A, 8'h00, 8'h00, 2, 1'b0);
        run_frame("wrC3", 8'h82, 8'hC3, 8'h00, 8'h00, 2, 1'b0);
        run_frame("rd2", 8'h02, 8'h00, 8'h00, 8'h00, 2, 1'b0);
        run_frame("wr3x", 8'h83, 8'h11, 8'h22, 8'h00, 3, 1'b0);
        run_frame("cmd_only", 8'h81, 8'h00, 8'h00, 8'h00, 1, 1'b0);
        run_frame("illegal", 8'h94, 8'h66, 8'h00, 8'h00, 2, 1'b0);
        run_frame("rd_ill", 8'h14, 8'h00, 8'h00, 8'h00, 2, 1'b0);
        run_frame("cs_drop", 8'h85, 8'h77, 8'h00, 8'h00, 2, 1'b1);
`ifdef SPI_AUTO_INC_EN
        run_frame("wrap", 8'hBF, 8'hAA, 8'hBB, 8'h00, 3, 1'b0);
        run_frame("rd_wrap", 8'h3E, 8'h00, 8'h00, 8'h00, 4, 1'b0);
`endif
        for (int k = 0; k < 60; k++) begin
            r0 = 8'($urandom);
            if ($urandom_range(0, 3) != 0) r0[5:4] = 2'b00;
            run_frame("rand", r0, 8'($urandom), 8'($urandom), 8'($urandom),
                      int'($urandom_range(1, 4)), ($urandom_range(0, 5) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
